product_host: RTL

//   Host-side driver for the team's nibble-serial multiplier tile.
//   - Accepts two OP_NIBBLES*4-bit operands over a valid/ready handshake.
//   - Serialises them as nibbles onto the tile's nibble/reset pins.
//   - Captures the product bytes the tile shifts out and reassembles them.
//   - Presents the full product over a valid/ready handshake.
//   - Shares clk with the tile; sits between a test/controller fabric and the tile.

---
 rtl/product_host_pkg.sv | 28 ++
 rtl/product_host_if.sv | 28 ++
 rtl/product_host.sv | 111 +++++++++++
 3 files changed

// File: rtl/product_host_pkg.sv
// Shared widths, FSM states and operand payload for the nibble-serial multiplier host.
package product_host_pkg;

  localparam int unsigned OP_NIBBLES  = 3;
  localparam int unsigned NIB_W       = 4;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned OP_W        = NIB_W * OP_NIBBLES;
  localparam int unsigned PROD_W      = 2 * OP_W;
  localparam int unsigned CAP_W       = PROD_W - BYTE_W;
  localparam int unsigned SEND_PHASES = 2 * OP_NIBBLES;
  localparam int unsigned RECV_PHASES = OP_NIBBLES - 1;
  localparam int unsigned PHASE_W     = $clog2(SEND_PHASES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    CALC = 3'd2,
    RECV = 3'd3,
    LAST = 3'd4
  } state_t;

  // Latched operand pair; A occupies the upper half so it is streamed first.
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operands_t;

endpackage

// File: rtl/product_host_if.sv
// Operand/product handshakes plus the multiplier tile pins.
interface product_host_if;
  import product_host_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_prod;
  logic              mul_reset;
  logic [NIB_W-1:0]  mul_nibble;
  logic [BYTE_W-1:0] mul_byte;

  // Fabric side (also models the tile pins in a test environment).
  modport master (
    output in_valid, in_a, in_b, out_ready, mul_byte,
    input  in_ready, out_valid, out_prod, mul_reset, mul_nibble
  );

  // Host block side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready, mul_byte,
    output in_ready, out_valid, out_prod, mul_reset, mul_nibble
  );

endinterface

// File: rtl/product_host.sv
// Drives the nibble-serial multiplier tile: streams A then B as nibbles,
// collects the product bytes and presents the full product over valid/ready.
module product_host
  import product_host_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  product_host_if.slave bus
);

  state_t              state, state_n;
  logic [PHASE_W-1:0]  phase, phase_n;
  logic [PROD_W-1:0]   sreg, sreg_n;
  logic [CAP_W-1:0]    cap, cap_n;
  logic [PROD_W-1:0]   prod, prod_n;
  logic                out_valid, out_valid_n;
  logic                in_ready, in_ready_n;
  logic                mul_reset, mul_reset_n;
  operands_t           ops_c;

  assign ops_c = '{a: bus.in_a, b: bus.in_b};

  // Tile pins come straight from flops; the shift register drains to zero after SEND.
  assign bus.mul_nibble = sreg[PROD_W-1 -: NIB_W];
  assign bus.mul_reset  = mul_reset;
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_prod   = prod;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= '0;
      sreg      <= '0;
      cap       <= '0;
      prod      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      mul_reset <= 1'b1;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      sreg      <= sreg_n;
      cap       <= cap_n;
      prod      <= prod_n;
      out_valid <= out_valid_n;
      in_ready  <= in_ready_n;
      mul_reset <= mul_reset_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    sreg_n      = sreg;
    cap_n       = cap;
    prod_n      = prod;
    out_valid_n = out_valid;
    mul_reset_n = mul_reset;

    if (out_valid && bus.out_ready) begin
      out_valid_n = 1'b0;
    end

    case (state)
      IDLE: begin
        mul_reset_n = 1'b1;
        if (bus.in_valid && in_ready) begin
          sreg_n      = ops_c;
          phase_n     = '0;
          mul_reset_n = 1'b0;
          state_n     = SEND;
        end
      end
      SEND: begin
        sreg_n  = sreg << NIB_W;
        phase_n = PHASE_W'(phase + 1'b1);
        if (phase == PHASE_W'(SEND_PHASES - 1)) begin
          phase_n = '0;
          state_n = CALC;
        end
      end
      CALC: begin
        phase_n = '0;
        state_n = RECV;
      end
      RECV: begin
        cap_n   = CAP_W'({cap, bus.mul_byte});
        phase_n = PHASE_W'(phase + 1'b1);
        if (phase == PHASE_W'(RECV_PHASES - 1)) begin
          mul_reset_n = 1'b1;
          state_n     = LAST;
        end
      end
      LAST: begin
        // Tile still presents the LSB byte while its reset is asserted.
        prod_n      = {cap, bus.mul_byte};
        out_valid_n = 1'b1;
        mul_reset_n = 1'b1;
        state_n     = IDLE;
      end
      default: begin
        mul_reset_n = 1'b1;
        state_n     = IDLE;
      end
    endcase

    in_ready_n = (state_n == IDLE) && !out_valid_n;
  end

endmodule
